// File: rtl/barrel_scheduler.sv
// Barrel slot allocator: grants the lowest free slot on each kong drop request,
// retires slots on barrel_done and flushes the whole pool at game over.
module barrel_scheduler #(
   parameter int unsigned NUM_BARRELS  = 8,
   parameter int unsigned FLUSH_CYCLES = 4
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   start,
   input  logic                   over,
   input  logic [3:0]             drop_count,
   input  logic [NUM_BARRELS-1:0] barrel_done,
   output logic [NUM_BARRELS-1:0] barrel_active,
   output logic [NUM_BARRELS-1:0] spawn,
   output logic [3:0]             spawn_id,
   output logic                   drop_miss,
   output logic [7:0]             miss_count,
   output logic [4:0]             active_count,
   output logic [1:0]             state
);

   localparam int unsigned FLUSH_LAST = FLUSH_CYCLES - 1;

   typedef enum logic [1:0] {
      IDLE  = 2'b00,
      RUN   = 2'b01,
      FLUSH = 2'b10,
      BAD   = 2'b11
   } state_t;

   state_t      state_q;
   logic [3:0]  last_drop;
   logic [7:0]  flush_cnt;
   logic        req;
   logic        free_found;
   logic [3:0]  free_idx;

   assign state = state_q;
   assign req   = (drop_count != last_drop);

   // Lowest-index free slot, taken from the pre-edge active mask
   always_comb begin
      free_found = 1'b0;
      free_idx   = 4'd0;
      for (int unsigned k = 0; k < NUM_BARRELS; k++) begin
         if (!barrel_active[k] && !free_found) begin
            free_found = 1'b1;
            free_idx   = 4'(k);
         end
      end
   end

   always_comb begin
      active_count = 5'd0;
      for (int unsigned k = 0; k < NUM_BARRELS; k++) begin
         active_count = active_count + 5'(barrel_active[k]);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= IDLE;
         barrel_active <= '0;
         spawn         <= '0;
         spawn_id      <= 4'd0;
         drop_miss     <= 1'b0;
         miss_count    <= 8'd0;
         last_drop     <= drop_count;
         flush_cnt     <= 8'd0;
      end else begin
         last_drop <= drop_count;
         spawn     <= '0;
         drop_miss <= 1'b0;
         case (state_q)
            IDLE: begin
               barrel_active <= '0;
               if (start) begin
                  state_q    <= RUN;
                  miss_count <= 8'd0;
               end
            end
            RUN: begin
               if (over) begin
                  // Pending drop request is discarded on the way out
                  state_q       <= FLUSH;
                  barrel_active <= '0;
                  flush_cnt     <= 8'd0;
               end else if (req && free_found) begin
                  barrel_active           <= (barrel_active & ~barrel_done)
                                             | (NUM_BARRELS'(1) << free_idx);
                  spawn                   <= NUM_BARRELS'(1) << free_idx;
                  spawn_id                <= free_idx;
               end else begin
                  barrel_active <= barrel_active & ~barrel_done;
                  if (req) begin
                     drop_miss <= 1'b1;
                     if (miss_count != 8'hFF) miss_count <= miss_count + 8'd1;
                  end
               end
            end
            FLUSH: begin
               barrel_active <= '0;
               if (32'(flush_cnt) >= FLUSH_LAST) begin
                  state_q <= IDLE;
               end else begin
                  flush_cnt <= flush_cnt + 8'd1;
               end
            end
            default: begin
               state_q       <= IDLE;
               barrel_active <= '0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_barrel_scheduler.sv
// Directed bench for barrel_scheduler: allocation order, misses, retire, wrap,
// flush timing and mid-run reset, against hand-computed values.
module tb_barrel_scheduler;

   logic       clk = 1'b0;
   logic       rst;
   logic       start;
   logic       over;
   logic [3:0] drop_count;
   logic [7:0] barrel_done;
   logic [7:0] barrel_active;
   logic [7:0] spawn;
   logic [3:0] spawn_id;
   logic       drop_miss;
   logic [7:0] miss_count;
   logic [4:0] active_count;
   logic [1:0] state;

   int checks   = 0;
   int failures = 0;

   barrel_scheduler #(.NUM_BARRELS(8), .FLUSH_CYCLES(4)) dut (
      .clk          (clk),
      .rst          (rst),
      .start        (start),
      .over         (over),
      .drop_count   (drop_count),
      .barrel_done  (barrel_done),
      .barrel_active(barrel_active),
      .spawn        (spawn),
      .spawn_id     (spawn_id),
      .drop_miss    (drop_miss),
      .miss_count   (miss_count),
      .active_count (active_count),
      .state        (state)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   initial begin
      rst = 1'b1; start = 1'b0; over = 1'b0; drop_count = 4'd5; barrel_done = 8'h00;
      tick(); tick();
      rst = 1'b0;
      check("rst_state", 32'(state), 32'h0);
      check("rst_active", 32'(barrel_active), 32'h0);
      check("rst_spawn", 32'(spawn), 32'h0);
      check("rst_spawn_id", 32'(spawn_id), 32'h0);
      check("rst_miss", 32'(drop_miss), 32'h0);
      check("rst_miss_count", 32'(miss_count), 32'h0);
      tick();

      // Start: drop_count has been 5 throughout IDLE, so no request
      start = 1'b1; tick(); start = 1'b0;
      check("start_state", 32'(state), 32'h1);
      check("start_active", 32'(barrel_active), 32'h0);
      tick();
      check("start_no_spawn", 32'(spawn), 32'h0);
      check("start_no_miss", 32'(drop_miss), 32'h0);

      drop_count = 4'd6; tick();
      check("sp1_spawn", 32'(spawn), 32'h01);
      check("sp1_id", 32'(spawn_id), 32'h0);
      drop_count = 4'd7; tick();
      check("sp2_spawn", 32'(spawn), 32'h02);
      check("sp2_id", 32'(spawn_id), 32'h1);
      check("sp2_active", 32'(barrel_active), 32'h03);
      check("sp2_count", 32'(active_count), 32'd2);
      tick();
      check("sp2_deassert", 32'(spawn), 32'h0);
      check("sp2_id_hold", 32'(spawn_id), 32'h1);

      // Fill slots 2..7
      for (int i = 8; i <= 13; i++) begin
         drop_count = 4'(i); tick();
      end
      check("fill_active", 32'(barrel_active), 32'hFF);
      check("fill_spawn", 32'(spawn), 32'h80);
      check("fill_id", 32'(spawn_id), 32'h7);
      check("fill_count", 32'(active_count), 32'd8);

      drop_count = 4'd14; tick();
      check("miss1_pulse", 32'(drop_miss), 32'h1);
      check("miss1_count", 32'(miss_count), 32'd1);
      check("miss1_spawn", 32'(spawn), 32'h0);
      check("miss1_active", 32'(barrel_active), 32'hFF);

      // Retire slot 3 on the same edge as a drop: still a miss
      drop_count = 4'd15; barrel_done = 8'h08; tick(); barrel_done = 8'h00;
      check("miss2_pulse", 32'(drop_miss), 32'h1);
      check("miss2_count", 32'(miss_count), 32'd2);
      check("miss2_active", 32'(barrel_active), 32'hF7);
      tick();
      check("miss2_deassert", 32'(drop_miss), 32'h0);

      drop_count = 4'd0; tick();
      check("reuse3_id", 32'(spawn_id), 32'h3);
      check("reuse3_spawn", 32'(spawn), 32'h08);
      check("reuse3_active", 32'(barrel_active), 32'hFF);

      // Retire slots 2..7 with a drop from full (miss), then wrap 15->0
      drop_count = 4'd15; barrel_done = 8'hFC; tick(); barrel_done = 8'h00;
      check("multi_retire", 32'(barrel_active), 32'h03);
      check("miss3_count", 32'(miss_count), 32'd3);
      drop_count = 4'd0; tick();
      check("wrap_id", 32'(spawn_id), 32'h2);
      check("wrap_spawn", 32'(spawn), 32'h04);
      check("wrap_active", 32'(barrel_active), 32'h07);

      barrel_done = 8'h08; tick(); barrel_done = 8'h00;
      check("done_inactive", 32'(barrel_active), 32'h07);
      drop_count = 4'd1; tick();
      check("pre_over_active", 32'(barrel_active), 32'h0F);
      check("pre_over_count", 32'(active_count), 32'd4);

      // Game over coinciding with a drop
      drop_count = 4'd2; over = 1'b1; tick(); over = 1'b0;
      check("over_state", 32'(state), 32'h2);
      check("over_active", 32'(barrel_active), 32'h0);
      check("over_spawn", 32'(spawn), 32'h0);
      check("over_miss", 32'(drop_miss), 32'h0);
      drop_count = 4'd9; barrel_done = 8'hFF; tick(); barrel_done = 8'h00;
      check("flush_ign_spawn", 32'(spawn), 32'h0);
      check("flush_c2", 32'(state), 32'h2);
      tick();
      check("flush_c3", 32'(state), 32'h2);
      tick();
      check("flush_c4", 32'(state), 32'h2);
      check("flush_active", 32'(barrel_active), 32'h0);
      tick();
      check("flush_to_idle", 32'(state), 32'h0);
      check("idle_miss_hold", 32'(miss_count), 32'd3);
      tick();

      start = 1'b1; tick(); start = 1'b0;
      check("restart_state", 32'(state), 32'h1);
      check("restart_miss_clr", 32'(miss_count), 32'd0);

      drop_count = 4'd5; tick();
      check("rerun_spawn", 32'(spawn), 32'h01);

      // Reset mid-RUN on the same edge as a drop
      drop_count = 4'd6; rst = 1'b1; tick(); rst = 1'b0;
      check("midrst_state", 32'(state), 32'h0);
      check("midrst_active", 32'(barrel_active), 32'h0);
      check("midrst_spawn", 32'(spawn), 32'h0);
      check("midrst_id", 32'(spawn_id), 32'h0);
      check("midrst_miss", 32'(drop_miss), 32'h0);
      check("midrst_count", 32'(active_count), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
